imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction loader and core-reset sequencer for `cpuCore`. It accepts a stream of instruction words on a valid/ready interface and writes each one into instruction memory through the core's debug write port (`dbg_wr_en`, `dbg_addr`, `dbg_instr`) with programmable setup and hold spacing. `cpuCore` is held in reset for the whole load. Core reset is released a fixed number of cycles after the last word is written.

## Interface
- `XLEN`, 64, core data/address width; width of `dbg_addr` and `load_base`.
- `INSTRUCTION_LENGTH`, XLEN/2, instruction word width.
- `SETUP_CYCLES`, 2, cycles for which address and data are stable before the write strobe; legal range ≥1.
- `HOLD_CYCLES`, 1, cycles for which address and data are held after the write strobe; legal range ≥1.
- `RELEASE_CYCLES`, 2, cycles between the last write's hold and core reset deassertion; legal range ≥1.

Ports:
- `clk` in 1: system clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load at `load_base`.
- `abort` in 1: cancels an in-progress load.
- `load_base` in XLEN: first instruction-memory address, sampled on accepted `start`.
- `s_valid` in 1: upstream instruction word valid.
- `s_ready` out 1: loader can accept a word.
- `s_instr` in INSTRUCTION_LENGTH: instruction word.
- `s_last` in 1: marks the final word of the program.
- `dbg_wr_en` out 1: instruction-memory write strobe to `cpuCore`.
- `dbg_addr` out XLEN: write address to `cpuCore`.
- `dbg_instr` out INSTRUCTION_LENGTH: write data to `cpuCore`.
- `core_rst` out 1: active-high reset to `cpuCore`.
- `busy` out 1: load in progress.
- `done` out 1: program loaded and core running.
- `word_count` out XLEN: words written since the last accepted `start`.

## Operation
- All outputs are registered.
- States: IDLE, FETCH, SETUP, WRITE, HOLD, RELEASE, RUN.
- Reset values: `core_rst`=1, `dbg_wr_en`=0, `dbg_addr`=0, `dbg_instr`=0, `s_ready`=0, `busy`=0, `done`=0, `word_count`=0, state=IDLE.
- IDLE: `core_rst`=1. On `start`: `dbg_addr`←`load_base`, `word_count`←0, go to FETCH.
- FETCH: `s_ready`=1. On `s_valid`: latch `s_instr` into `dbg_instr`, latch `s_last`, go to SETUP.
- SETUP: lasts SETUP_CYCLES. `dbg_addr` and `dbg_instr` are stable. Then go to WRITE.
- WRITE: lasts exactly 1 cycle with `dbg_wr_en`=1. Then go to HOLD.
- HOLD: lasts HOLD_CYCLES. `dbg_addr` and `dbg_instr` are unchanged. On exit `word_count`+1.
  - If the latched last flag is 0: `dbg_addr`+1 (wraps modulo 2^XLEN), go to FETCH.
  - If the flag is 1: go to RELEASE, and `dbg_addr` does not increment.
- RELEASE: lasts RELEASE_CYCLES with `core_rst`=1. Then go to RUN.
- RUN: `core_rst`=0, `done`=1. On `start`: `core_rst`←1, `done`←0, reload sequence as from IDLE.
- `busy`=1 in FETCH, SETUP, WRITE, HOLD and RELEASE.
- `start` is ignored while `busy`=1.
- `abort`:
  - Sampled in any busy state. On the next edge: state=IDLE, `dbg_wr_en`=0, `s_ready`=0, `core_rst` stays 1, `word_count` keeps its value.
  - An abort sampled during WRITE does not cancel that write; the strobe has already been driven that cycle.
  - `abort` has priority over `start` and over the FETCH handshake.
- `s_ready` is 0 outside FETCH. No word is consumed outside FETCH.
- An asynchronous `rst_n` assertion mid-load immediately forces all reset values, including `dbg_wr_en`=0 and `core_rst`=1.

## Timing
- Write strobe timing (handshake in FETCH at cycle t):
  - `dbg_addr` and `dbg_instr` are valid from cycle t+1.
  - `dbg_wr_en` is high in cycle t+1+SETUP_CYCLES.
  - Outputs are held through cycle t+1+SETUP_CYCLES+HOLD_CYCLES.
  - FETCH is re-entered at t+2+SETUP_CYCLES+HOLD_CYCLES.
- Throughput: one word per 2+SETUP_CYCLES+HOLD_CYCLES cycles with `s_valid` always high; this is 5 cycles with defaults.
- `core_rst` falls RELEASE_CYCLES cycles after the last HOLD cycle ends. `done` rises in the same cycle.
- Latency from `start` to `s_ready`=1: 1 cycle.
- `dbg_wr_en` is never high for 2 consecutive cycles.

## Test plan
- Four-word load with defaults, `load_base`=0, words 0x003130A3, 0x0120000F, 0x00520333, 0x00743483 (`s_last` on the 4th):
  - Exactly 4 single-cycle `dbg_wr_en` pulses, at addresses 0, 1, 2, 3 with the matching data.
  - Each pulse preceded by 2 and followed by 1 stable cycles.
  - `core_rst` drops 2 cycles after the final HOLD; `word_count`=4, `done`=1.
- Backpressure: `s_valid` low for 7 cycles in FETCH:
  - No `dbg_wr_en` and no state advance during the gap.
  - Resumes correctly and the address sequence has no gap.
- Address wrap: `load_base`=2^XLEN−1 with 2 words → writes at 0xFFFF…FFFF, then 0.
- Abort during SETUP of word 2 → no write for word 2, `core_rst` stays 1, `word_count`=1, `busy`=0. A new `start` reloads from `load_base`.
- `rst_n` pulsed low in the WRITE cycle → `dbg_wr_en` and `busy` go to 0 asynchronously and `core_rst`=1. `start` ignored while busy → no effect on address or count.
- Reload from RUN: `start` → `core_rst` rises next cycle, `done`=0, and a full reload runs with `word_count` restarting at 0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction loader: streams words into cpuCore instruction memory
// through the debug write port, then sequences the core out of reset.
module imem_loader #(
  parameter int XLEN               = 64,
  parameter int INSTRUCTION_LENGTH = XLEN/2,
  parameter int SETUP_CYCLES       = 2,
  parameter int HOLD_CYCLES        = 1,
  parameter int RELEASE_CYCLES     = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [XLEN-1:0]               load_base,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [INSTRUCTION_LENGTH-1:0] s_instr,
  input  logic                          s_last,
  output logic                          dbg_wr_en,
  output logic [XLEN-1:0]               dbg_addr,
  output logic [INSTRUCTION_LENGTH-1:0] dbg_instr,
  output logic                          core_rst,
  output logic                          busy,
  output logic                          done,
  output logic [XLEN-1:0]               word_count
);

  localparam int CW = 32;

  typedef enum logic [2:0] {
    IDLE, FETCH, SETUP, WRITE, HOLD, RELEASE, RUN
  } state_t;

  state_t                        state, state_nxt;
  logic [CW-1:0]                 cnt, cnt_d;
  logic                          last_q, last_d;
  logic                          s_ready_d, wr_en_d, core_rst_d, busy_d, done_d;
  logic [XLEN-1:0]               addr_d, wc_d;
  logic [INSTRUCTION_LENGTH-1:0] instr_d;
  logic                          cur_busy, counting;

  function automatic logic is_busy(input state_t s);
    return (s == FETCH) || (s == SETUP) || (s == WRITE) ||
           (s == HOLD)  || (s == RELEASE);
  endfunction

  assign cur_busy = is_busy(state);
  assign counting = (state == SETUP) || (state == HOLD) || (state == RELEASE);

  // State register; every output is a flop fed from the output-comb process.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_q     <= 1'b0;
      s_ready    <= 1'b0;
      dbg_wr_en  <= 1'b0;
      dbg_addr   <= '0;
      dbg_instr  <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_d;
      last_q     <= last_d;
      s_ready    <= s_ready_d;
      dbg_wr_en  <= wr_en_d;
      dbg_addr   <= addr_d;
      dbg_instr  <= instr_d;
      core_rst   <= core_rst_d;
      busy       <= busy_d;
      done       <= done_d;
      word_count <= wc_d;
    end
  end

  // Next-state logic; abort overrides start and the FETCH handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (s_valid) state_nxt = SETUP;
      SETUP:   if (cnt == CW'(SETUP_CYCLES - 1)) state_nxt = WRITE;
      WRITE:   state_nxt = HOLD;
      HOLD:    if (cnt == CW'(HOLD_CYCLES - 1))
                 state_nxt = last_q ? RELEASE : FETCH;
      RELEASE: if (cnt == CW'(RELEASE_CYCLES - 1)) state_nxt = RUN;
      RUN:     if (start) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
    if (cur_busy && abort) state_nxt = IDLE;
  end

  // Output logic: values presented in the cycle the machine enters state_nxt.
  always_comb begin
    cnt_d      = (counting && state_nxt == state) ? cnt + 1'b1 : '0;
    last_d     = last_q;
    instr_d    = dbg_instr;
    addr_d     = dbg_addr;
    wc_d       = word_count;
    s_ready_d  = (state_nxt == FETCH);
    wr_en_d    = (state_nxt == WRITE);
    busy_d     = is_busy(state_nxt);
    done_d     = (state_nxt == RUN);
    core_rst_d = (state_nxt != RUN);

    if ((state == IDLE || state == RUN) && state_nxt == FETCH) begin
      addr_d = load_base;
      wc_d   = '0;
    end
    if (state == FETCH && state_nxt == SETUP) begin
      instr_d = s_instr;
      last_d  = s_last;
    end
    // The final word leaves the address on itself; others advance (mod 2^XLEN).
    if (state == HOLD && state_nxt == FETCH) begin
      addr_d = dbg_addr + 1'b1;
      wc_d   = word_count + 1'b1;
    end
    if (state == HOLD && state_nxt == RELEASE)
      wc_d = word_count + 1'b1;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; writes are checked by a scoreboard monitor.
module tb_imem_loader;
  localparam int XLEN = 64;
  localparam int IL   = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, abort = 1'b0;
  logic [XLEN-1:0] load_base = '0;
  logic            s_valid = 1'b0, s_last = 1'b0;
  logic [IL-1:0]   s_instr = '0;
  logic            s_ready, dbg_wr_en, core_rst, busy, done;
  logic [XLEN-1:0] dbg_addr, word_count;
  logic [IL-1:0]   dbg_instr;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .load_base(load_base), .s_valid(s_valid), .s_ready(s_ready),
    .s_instr(s_instr), .s_last(s_last), .dbg_wr_en(dbg_wr_en),
    .dbg_addr(dbg_addr), .dbg_instr(dbg_instr), .core_rst(core_rst),
    .busy(busy), .done(done), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0, cyc = 0;
  logic [XLEN-1:0] exp_a[$];
  logic [IL-1:0]   exp_d[$];
  int              pulse_cyc[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected writes, checks setup/hold stability and strobe width.
  logic [XLEN-1:0] pa1, pa2, ha;
  logic [IL-1:0]   pi1, pi2, hi;
  logic            prev_wr = 1'b0, hold_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
      prev_wr   = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_stable", {31'd0, (dbg_addr == ha && dbg_instr == hi && !dbg_wr_en)}, 64'd1);
        hold_pend = 1'b0;
      end
      if (dbg_wr_en) begin
        pulse_cyc.push_back(cyc);
        if (exp_a.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_write: got addr %0h data %0h want none", dbg_addr, dbg_instr);
        end else begin
          chk("wr_addr", dbg_addr, exp_a.pop_front());
          chk("wr_data", {32'd0, dbg_instr}, {32'd0, exp_d.pop_front()});
        end
        chk("setup_stable", {31'd0, (pa1 == dbg_addr && pa2 == dbg_addr &&
            pi1 == dbg_instr && pi2 == dbg_instr && !prev_wr)}, 64'd1);
        ha = dbg_addr; hi = dbg_instr; hold_pend = 1'b1;
      end
    end
    pa2 = pa1; pa1 = dbg_addr;
    pi2 = pi1; pi1 = dbg_instr;
    prev_wr = dbg_wr_en;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [XLEN-1:0] base);
    load_base = base; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic accept(input logic [IL-1:0] w, input logic last);
    int n = 0;
    s_valid = 1'b1; s_instr = w; s_last = last;
    while (!s_ready && n < 100) begin tick(); n++; end
    chk("ready_wait", {63'd0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send(input logic [IL-1:0] w, input logic last, input logic [XLEN-1:0] a);
    exp_a.push_back(a); exp_d.push_back(w);
    accept(w, last);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("done_wait", {63'd0, done}, 64'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_core_rst", {63'd0, core_rst}, 64'd1);
    chk("rst_outs", {59'd0, dbg_wr_en, s_ready, busy, done, 1'b0}, 64'd0);
    chk("rst_addr", dbg_addr, 64'd0);
    chk("rst_wc", word_count, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Four-word load with defaults
    do_start(64'd0);
    chk("t1_ready_latency", {62'd0, s_ready, busy}, 64'd3);
    send(32'h003130A3, 1'b0, 64'd0);
    send(32'h0120000F, 1'b0, 64'd1);
    send(32'h00520333, 1'b0, 64'd2);
    send(32'h00743483, 1'b1, 64'd3);
    repeat (5) tick();
    chk("t1_rst_held", {62'd0, core_rst, done}, 64'd2);
    tick();
    chk("t1_rst_release", {62'd0, core_rst, done}, 64'd1);
    chk("t1_wc", word_count, 64'd4);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_pulses", pulse_cyc.size(), 64'd4);
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("t1_spacing", pulse_cyc[i] - pulse_cyc[i-1], 64'd5);

    // Reload from RUN, with backpressure gap
    do_start(64'h100);
    chk("t2_core_rst", {62'd0, core_rst, done}, 64'd2);
    chk("t2_wc_clear", word_count, 64'd0);
    chk("t2_base", dbg_addr, 64'h100);
    send(32'hAAAA0001, 1'b0, 64'h100);
    for (int n = 0; n < 20 && !s_ready; n++) tick();
    for (int i = 0; i < 7; i++) begin
      chk("t2_gap", {dbg_addr[61:0], s_ready, dbg_wr_en}, {62'h101, 1'b1, 1'b0});
      tick();
    end
    send(32'hAAAA0002, 1'b1, 64'h101);
    wait_done();
    chk("t2_wc", word_count, 64'd2);

    // Address wrap
    do_start({XLEN{1'b1}});
    send(32'h11110000, 1'b0, {XLEN{1'b1}});
    send(32'h22220000, 1'b1, 64'd0);
    wait_done();
    chk("t3_wc", word_count, 64'd2);
    chk("t3_addr_final", dbg_addr, 64'd0);

    // Abort in SETUP of word 2
    do_start(64'h40);
    send(32'h33330001, 1'b0, 64'h40);
    accept(32'h33330002, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_state", {60'd0, busy, core_rst, s_ready, dbg_wr_en}, 64'b0100);
    chk("t4_wc", word_count, 64'd1);
    repeat (10) tick();
    chk("t4_idle", {62'd0, busy, core_rst}, 64'b01);
    do_start(64'h40);
    chk("t4_restart_addr", dbg_addr, 64'h40);
    chk("t4_restart_wc", word_count, 64'd0);
    send(32'h33330003, 1'b1, 64'h40);
    wait_done();
    chk("t4_wc_final", word_count, 64'd1);

    // start ignored while busy, then rst_n during WRITE
    do_start(64'h80);
    load_base = 64'h999; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_ign_addr", dbg_addr, 64'h80);
    chk("t5_ign_wc", word_count, 64'd0);
    chk("t5_ign_busy", {62'd0, busy, s_ready}, 64'b11);
    send(32'h44440001, 1'b0, 64'h80);
    accept(32'h44440002, 1'b0);
    tick(); tick();
    chk("t5_in_write", {63'd0, dbg_wr_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_async", {61'd0, dbg_wr_en, busy, core_rst}, 64'b001);
    chk("t5_async_wc", word_count, 64'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle_after", {62'd0, busy, core_rst}, 64'b01);

    chk("sb_empty", exp_a.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
